// File: rtl/wb_dma_defs.sv
// Shared definitions for the descriptor fetch master: FSM states,
// descriptor word offsets and field bit positions.
package wb_dma_defs;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RTY  = 3'd2,
    ST_DONE = 3'd3,
    ST_FAIL = 3'd4
  } fetch_state_e;

  localparam int unsigned DESC_WORDS = 4;
  localparam int unsigned BEAT_W     = 2;

  // Descriptor word offsets within the 4-word burst
  localparam logic [BEAT_W-1:0] WORD_STATE = 2'd0;
  localparam logic [BEAT_W-1:0] WORD_ADDR  = 2'd1;
  localparam logic [BEAT_W-1:0] WORD_NEXT  = 2'd2;
  localparam logic [BEAT_W-1:0] WORD_LAST  = BEAT_W'(DESC_WORDS - 1);

  // Field bit positions inside a descriptor word
  localparam int unsigned STATE_MSB = 31;
  localparam int unsigned STATE_LSB = 24;
  localparam int unsigned DESC_MSB  = 15;
  localparam int unsigned DESC_LSB  = 0;
  localparam int unsigned PTR_MSB   = 31;
  localparam int unsigned PTR_LSB   = 3;

  // Next beat address; 32-bit add, wraps silently past 32'hffff_fffc
  function automatic logic [31:0] beat_adr(input logic [31:0] adr);
    return adr + 32'd4;
  endfunction

endpackage

// File: rtl/wb_beat_timer.sv
// Per-beat ack watchdog and retry counter for wb_desc_fetch.
// Watchdog is present only when WB_FETCH_TIMEOUT_EN is defined.
module wb_beat_timer #(
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned MAX_RTY = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic tmo_inc_i,
  input  logic rty_inc_i,
  output logic tmo_expire_o,
  output logic rty_last_o
);

  localparam int unsigned RTY_W = $clog2(MAX_RTY + 1);

  logic [RTY_W-1:0] rty_cnt_q, rty_cnt_d;

  // Retry count: cleared on each new beat, bumped per rty
  always_comb begin
    rty_cnt_d = rty_cnt_q;
    if (clr_i)          rty_cnt_d = '0;
    else if (rty_inc_i) rty_cnt_d = rty_cnt_q + RTY_W'(1);
  end

  // Retry counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) rty_cnt_q <= '0;
    else       rty_cnt_q <= rty_cnt_d;
  end

  // The pending rty is the one that exhausts the budget
  assign rty_last_o = (rty_cnt_q == RTY_W'(MAX_RTY - 1));

`ifdef WB_FETCH_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Watchdog: saturating count of waiting cycles in the current beat
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (clr_i)                                 tmo_cnt_d = '0;
    else if (tmo_inc_i && tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  end

  // Watchdog register
  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end

  // Expires on the cycle the count steps onto all-ones: 2**TMO_W-1 waiting cycles
  assign tmo_expire_o = tmo_inc_i && (tmo_cnt_q == TMO_LAST);
`else
  logic unused_tmo;
  assign unused_tmo   = tmo_inc_i;
  assign tmo_expire_o = 1'b0;
`endif

endmodule

// File: rtl/wb_desc_fetch.sv
// Wishbone master fetching one 4-word scatter/gather descriptor.
// Optional per-beat ack watchdog: define WB_FETCH_TIMEOUT_EN.
module wb_desc_fetch
  import wb_dma_defs::*;
#(
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned MAX_RTY = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [28:0] desc_ptr,
  output logic        busy,
  output logic        done,
  output logic        fetch_err,
  output logic [7:0]  sg_state,
  output logic [15:0] sg_desc,
  output logic [28:0] sg_addr,
  output logic [28:0] sg_next,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cab_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i
);

  fetch_state_e      state_q, state_d;
  logic [BEAT_W-1:0] beat_q;
  logic [31:0]       adr_q;
  logic [7:0]        sh_state_q;
  logic [15:0]       sh_desc_q;
  logic [28:0]       sh_addr_q;
  logic [28:0]       sh_next_q;
  logic [7:0]        sg_state_q;
  logic [15:0]       sg_desc_q;
  logic [28:0]       sg_addr_q;
  logic [28:0]       sg_next_q;

  logic in_req, beat_accept, tmr_clr, rty_hit, tmo_expire, rty_last;
  logic unused_dat;

  assign unused_dat  = ^{wbm_dat_i[23:16], wbm_dat_i[2:0]};
  assign in_req      = (state_q == ST_REQ);
  assign beat_accept = in_req && !wbm_err_i && !wbm_rty_i && wbm_ack_i;
  assign rty_hit     = in_req && !wbm_err_i && wbm_rty_i;
  assign tmr_clr     = (state_q == ST_IDLE) || beat_accept;

  wb_beat_timer #(
    .TMO_W   (TMO_W),
    .MAX_RTY (MAX_RTY)
  ) u_timer (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .clr_i        (tmr_clr),
    .tmo_inc_i    (in_req),
    .rty_inc_i    (rty_hit),
    .tmo_expire_o (tmo_expire),
    .rty_last_o   (rty_last)
  );

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state; REQ priority is err > rty > ack > timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;
      ST_REQ: begin
        if (wbm_err_i)      state_d = ST_FAIL;
        else if (wbm_rty_i) state_d = rty_last ? ST_FAIL : ST_RTY;
        else if (wbm_ack_i) state_d = (beat_q == WORD_LAST) ? ST_DONE : ST_REQ;
        else if (tmo_expire) state_d = ST_FAIL;
      end
      ST_RTY:  state_d = ST_REQ;
      ST_DONE: state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus and status outputs decoded from state
  always_comb begin
    wbm_cyc_o = (state_q == ST_REQ) || (state_q == ST_RTY);
    wbm_stb_o = (state_q == ST_REQ);
    wbm_cab_o = wbm_cyc_o && (beat_q != WORD_LAST);
    busy      = wbm_cyc_o;
    done      = (state_q == ST_DONE);
    fetch_err = (state_q == ST_FAIL);
  end

  // Beat/address tracking, shadow capture; fields commit on the last ack
  // so they are already valid during the done pulse
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      beat_q     <= '0;
      adr_q      <= '0;
      sh_state_q <= '0;
      sh_desc_q  <= '0;
      sh_addr_q  <= '0;
      sh_next_q  <= '0;
      sg_state_q <= '0;
      sg_desc_q  <= '0;
      sg_addr_q  <= '0;
      sg_next_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        beat_q <= '0;
        adr_q  <= {desc_ptr, 3'b000};
      end
      if (beat_accept) begin
        unique case (beat_q)
          WORD_STATE: begin
            sh_state_q <= wbm_dat_i[STATE_MSB:STATE_LSB];
            sh_desc_q  <= wbm_dat_i[DESC_MSB:DESC_LSB];
          end
          WORD_ADDR: sh_addr_q <= wbm_dat_i[PTR_MSB:PTR_LSB];
          WORD_NEXT: sh_next_q <= wbm_dat_i[PTR_MSB:PTR_LSB];
          default: begin
            sg_state_q <= sh_state_q;
            sg_desc_q  <= sh_desc_q;
            sg_addr_q  <= sh_addr_q;
            sg_next_q  <= sh_next_q;
          end
        endcase
        if (beat_q != WORD_LAST) begin
          beat_q <= beat_q + BEAT_W'(1);
          adr_q  <= beat_adr(adr_q);
        end
      end
    end
  end

  assign wbm_adr_o = adr_q;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hf;
  assign sg_state  = sg_state_q;
  assign sg_desc   = sg_desc_q;
  assign sg_addr   = sg_addr_q;
  assign sg_next   = sg_next_q;

endmodule

// File: tb/tb_wb_desc_fetch.sv
// Directed bench for wb_desc_fetch with a scripted Wishbone slave.
// Build with WB_FETCH_TIMEOUT_EN to exercise the watchdog case.
module tb_wb_desc_fetch;

  logic        clk = 1'b0;
  logic        wb_rst_i, start;
  logic [28:0] desc_ptr;
  logic        busy, done, fetch_err;
  logic [7:0]  sg_state;
  logic [15:0] sg_desc;
  logic [28:0] sg_addr, sg_next;
  logic [31:0] wbm_adr_o, wbm_dat_i;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

  always #5 clk = ~clk;

  wb_desc_fetch #(.TMO_W(4), .MAX_RTY(3)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start(start), .desc_ptr(desc_ptr),
    .busy(busy), .done(done), .fetch_err(fetch_err),
    .sg_state(sg_state), .sg_desc(sg_desc), .sg_addr(sg_addr), .sg_next(sg_next),
    .wbm_adr_o(wbm_adr_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_cab_o(wbm_cab_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .wbm_rty_i(wbm_rty_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave script
  logic [31:0] mem [4];
  logic [31:0] base;
  int          cfg_wait, cfg_err_beat, cfg_rty_beat, cfg_rty_n;
  bit          cfg_noack;
  int          wait_cnt, rty_seen, ack_cnt, bt;
  logic [31:0] ack_adr [8];
  logic        ack_cab [8];
  logic [31:0] wait_adr;
  bit          adr_moved, both_pulses;

  // Scripted slave: responds at negedge for the next posedge
  always @(negedge clk) begin
    if (done && fetch_err) both_pulses = 1'b1;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = '0;
    if (wbm_stb_o) begin
      bt = int'((wbm_adr_o - base) >> 2);
      if (wait_cnt == 0) wait_adr = wbm_adr_o;
      else if (wbm_adr_o != wait_adr) adr_moved = 1'b1;
      if (wait_cnt < cfg_wait) wait_cnt++;
      else if (cfg_noack) wait_cnt = wait_cnt;
      else if (bt == cfg_err_beat) wbm_err_i = 1'b1;
      else if (bt == cfg_rty_beat && rty_seen < cfg_rty_n) begin
        wbm_rty_i = 1'b1;
        rty_seen++;
        wait_cnt = 0;
      end else begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = mem[bt & 3];
        if (ack_cnt < 8) begin
          ack_adr[ack_cnt] = wbm_adr_o;
          ack_cab[ack_cnt] = wbm_cab_o;
        end
        ack_cnt++;
        wait_cnt = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic setup(input logic [28:0] ptr, input int w, input int eb,
                       input int rb, input int rn, input bit noack);
    desc_ptr     = ptr;
    base         = {ptr, 3'b000};
    cfg_wait     = w;
    cfg_err_beat = eb;
    cfg_rty_beat = rb;
    cfg_rty_n    = rn;
    cfg_noack    = noack;
    wait_cnt     = 0;
    rty_seen     = 0;
    ack_cnt      = 0;
    adr_moved    = 1'b0;
  endtask

  task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
  endtask

  // Pulse start, wait (bounded) for done or fetch_err; lat counts negedges after start
  task automatic run_fetch(input int limit, output int lat, output bit gd,
                           output bit ge, output logic cyc_at_end);
    @(negedge clk);
    start = 1'b1;
    lat = 0; gd = 1'b0; ge = 1'b0; cyc_at_end = 1'bx;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (done) gd = 1'b1;
      if (fetch_err) ge = 1'b1;
      if (gd || ge) begin
        lat = n;
        cyc_at_end = wbm_cyc_o;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_fields(input string tag, input logic [7:0] st, input logic [15:0] ds,
                              input logic [28:0] ad, input logic [28:0] nx);
    check({tag, "_state"}, 64'(sg_state), 64'(st));
    check({tag, "_desc"},  64'(sg_desc),  64'(ds));
    check({tag, "_addr"},  64'(sg_addr),  64'(ad));
    check({tag, "_next"},  64'(sg_next),  64'(nx));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int   lat;
    bit   gd, ge;
    logic cyc_end;
    bit   seen;

    wb_rst_i = 1'b1; start = 1'b0; both_pulses = 1'b0;
    load('0, '0, '0, '0);
    setup(29'h0, 0, -1, -1, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_cyc",  64'(wbm_cyc_o), 64'd0);
    check("rst_stb",  64'(wbm_stb_o), 64'd0);
    check("rst_cab",  64'(wbm_cab_o), 64'd0);
    check("rst_busy", 64'(busy),      64'd0);
    check("rst_done", 64'(done),      64'd0);
    check("rst_err",  64'(fetch_err), 64'd0);
    check("rst_adr",  64'(wbm_adr_o), 64'd0);
    check_fields("rst", 8'h0, 16'h0, 29'h0, 29'h0);
    wb_rst_i = 1'b0;

    // 1: zero wait states
    load(32'h8100_0040, 32'h1000_0008, 32'h2000_0010, 32'h0);
    setup(29'h0200_0000, 0, -1, -1, 0, 1'b0);
    run_fetch(50, lat, gd, ge, cyc_end);
    check("t1_done", 64'(gd), 64'd1);
    check("t1_err",  64'(ge), 64'd0);
    check("t1_lat",  64'(lat), 64'd5);
    check("t1_acks", 64'(ack_cnt), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_adr%0d", i), 64'(ack_adr[i]), 64'(32'h1000_0000 + 32'(4 * i)));
      check($sformatf("t1_cab%0d", i), 64'(ack_cab[i]), 64'(i != 3));
    end
    check("t1_we",  64'(wbm_we_o),  64'd0);
    check("t1_sel", 64'(wbm_sel_o), 64'hf);
    check_fields("t1", 8'h81, 16'h0040, 29'h0200_0001, 29'h0400_0002);
    @(negedge clk);
    check("t1_idle_busy", 64'(busy), 64'd0);
    check("t1_idle_cyc",  64'(wbm_cyc_o), 64'd0);

    // 2: three wait states per beat
    setup(29'h0200_0000, 3, -1, -1, 0, 1'b0);
    run_fetch(100, lat, gd, ge, cyc_end);
    check("t2_done", 64'(gd), 64'd1);
    check("t2_lat",  64'(lat), 64'd17);
    check("t2_acks", 64'(ack_cnt), 64'd4);
    check("t2_adr_stable", 64'(adr_moved), 64'd0);
    check_fields("t2", 8'h81, 16'h0040, 29'h0200_0001, 29'h0400_0002);

    // 3: bus error on beat 2; previous fields must survive
    load(32'h5a00_beef, 32'hcafe_0018, 32'h0000_0100, 32'hffff_ffff);
    setup(29'h0100_0000, 0, 2, -1, 0, 1'b0);
    run_fetch(50, lat, gd, ge, cyc_end);
    check("t3_err",  64'(ge), 64'd1);
    check("t3_done", 64'(gd), 64'd0);
    check("t3_lat",  64'(lat), 64'd4);
    check("t3_cyc",  64'(cyc_end), 64'd0);
    check("t3_acks", 64'(ack_cnt), 64'd2);
    check_fields("t3", 8'h81, 16'h0040, 29'h0200_0001, 29'h0400_0002);

    // 4a: three retries on beat 1 exhaust the budget
    setup(29'h0100_0000, 0, -1, 1, 3, 1'b0);
    run_fetch(50, lat, gd, ge, cyc_end);
    check("t4a_err",  64'(ge), 64'd1);
    check("t4a_lat",  64'(lat), 64'd7);
    check("t4a_rty",  64'(rty_seen), 64'd3);
    check_fields("t4a", 8'h81, 16'h0040, 29'h0200_0001, 29'h0400_0002);

    // 4b: two retries then ack completes
    setup(29'h0100_0000, 0, -1, 1, 2, 1'b0);
    run_fetch(50, lat, gd, ge, cyc_end);
    check("t4b_done", 64'(gd), 64'd1);
    check("t4b_err",  64'(ge), 64'd0);
    check("t4b_lat",  64'(lat), 64'd9);
    check("t4b_adr1", 64'(ack_adr[1]), 64'h0800_0004);
    check_fields("t4b", 8'h5a, 16'hbeef, 29'h195f_c003, 29'h0000_0020);

    // 5a: second start while busy is ignored
    load(32'h8100_0040, 32'h1000_0008, 32'h2000_0010, 32'h0);
    setup(29'h0200_0000, 1, -1, -1, 0, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); desc_ptr = 29'h0300_0000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("t5a_done", 64'(seen), 64'd1);
    repeat (10) @(negedge clk);
    check("t5a_acks", 64'(ack_cnt), 64'd4);
    check("t5a_adr3", 64'(ack_adr[3]), 64'h1000_000c);
    check("t5a_cyc",  64'(wbm_cyc_o), 64'd0);

    // 5b: reset while beat 2 is on the bus
    setup(29'h0200_0000, 0, -1, -1, 0, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (wbm_stb_o && wbm_adr_o == 32'h1000_0008) seen = 1'b1;
      else @(negedge clk);
    end
    check("t5b_reached_beat2", 64'(seen), 64'd1);
    wb_rst_i = 1'b1;
    @(negedge clk);
    check("t5b_cyc",  64'(wbm_cyc_o), 64'd0);
    check("t5b_stb",  64'(wbm_stb_o), 64'd0);
    check("t5b_busy", 64'(busy), 64'd0);
    check("t5b_done", 64'(done), 64'd0);
    check_fields("t5b", 8'h0, 16'h0, 29'h0, 29'h0);
    wb_rst_i = 1'b0;

    // 6: slave never acks
    setup(29'h0200_0000, 0, -1, -1, 0, 1'b1);
`ifdef WB_FETCH_TIMEOUT_EN
    run_fetch(50, lat, gd, ge, cyc_end);
    check("t6_err",  64'(ge), 64'd1);
    check("t6_done", 64'(gd), 64'd0);
    check("t6_lat",  64'(lat), 64'd16);
`else
    run_fetch(100, lat, gd, ge, cyc_end);
    check("t6_no_end", 64'(gd || ge), 64'd0);
    check("t6_busy",   64'(busy), 64'd1);
    wb_rst_i = 1'b1;
    @(negedge clk);
    wb_rst_i = 1'b0;
`endif
    @(negedge clk);
    check("pulses_exclusive", 64'(both_pulses), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
